// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack handshake, one-entry skid buffer.
// Optional FETCH_HALT_DETECT_EN: a fetched HALT word stops the stage.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2,
    parameter logic [15:0] NOP      = 16'b1110100000000000,
    parameter logic [15:0] HALT     = 16'b1110000000000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] next_pc_out,
    output logic [15:0] true_pc_out,
    output logic        valid_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH, S_WAIT, S_HOLD, S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] tpc_q, tpc_d;
    logic [15:0] npc_q, npc_d;
    logic [15:0] sk_instr_q, sk_instr_d;
    logic [15:0] sk_pc_q, sk_pc_d;
    logic        req_q, req_d;
    logic        kill_q, kill_d;
    logic        skid_q, skid_d;
    logic        valid_q, valid_d;

    logic        ack, live_ack;
    logic        sel_hlt, sel_halt, sel_redir, sel_stall;
    logic [15:0] pc_inc;

    assign ack      = req_q & imem_ack;
    assign live_ack = ack & ~kill_q;
    assign pc_inc   = pc_q + PC_INC;

    // One-hot priority: halted > halt > redirect > stall > normal
    assign sel_hlt   = (state_q == S_HALTED);
    assign sel_halt  = ~sel_hlt & halt;
    assign sel_redir = ~sel_hlt & ~halt & redirect;
    assign sel_stall = ~sel_hlt & ~halt & ~redirect & stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= NOP;
            tpc_q      <= '0;
            npc_q      <= '0;
            sk_instr_q <= '0;
            sk_pc_q    <= '0;
            req_q      <= 1'b0;
            kill_q     <= 1'b0;
            skid_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            tpc_q      <= tpc_d;
            npc_q      <= npc_d;
            sk_instr_q <= sk_instr_d;
            sk_pc_q    <= sk_pc_d;
            req_q      <= req_d;
            kill_q     <= kill_d;
            skid_q     <= skid_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        tpc_d      = tpc_q;
        npc_d      = npc_q;
        sk_instr_d = sk_instr_q;
        sk_pc_d    = sk_pc_q;
        req_d      = req_q;
        kill_d     = kill_q;
        skid_d     = skid_q;
        valid_d    = valid_q;
        unique case (1'b1)
            sel_hlt: begin
                req_d = req_q & ~imem_ack;
            end
            sel_halt: begin
                instr_d = HALT;
                tpc_d   = '0;
                npc_d   = '0;
                valid_d = 1'b0;
                skid_d  = 1'b0;
                kill_d  = 1'b0;
                req_d   = req_q & ~imem_ack;
                state_d = S_HALTED;
            end
            sel_redir: begin
                pc_d    = redirect_pc;
                instr_d = NOP;
                valid_d = 1'b0;
                skid_d  = 1'b0;
                req_d   = 1'b1;
                if (req_q && !imem_ack) begin
                    kill_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    kill_d  = 1'b0;
                    addr_d  = redirect_pc;
                    state_d = S_FETCH;
                end
            end
            sel_stall: begin
                if (ack) begin
                    req_d   = 1'b0;
                    kill_d  = 1'b0;
                    state_d = S_HOLD;
                    if (!kill_q) begin
                        skid_d     = 1'b1;
                        sk_instr_d = imem_rdata;
                        sk_pc_d    = pc_q;
                        pc_d       = pc_inc;
                    end
                end else begin
                    state_d = req_q ? S_WAIT : S_HOLD;
                end
            end
            default: begin
                if (skid_q) begin
                    instr_d = sk_instr_q;
                    tpc_d   = sk_pc_q;
                    npc_d   = sk_pc_q + PC_INC;
                    valid_d = 1'b1;
                    skid_d  = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_FETCH;
`ifdef FETCH_HALT_DETECT_EN
                    if (sk_instr_q == HALT) begin
                        req_d   = 1'b0;
                        state_d = S_HALTED;
                    end
`endif
                end else if (live_ack) begin
                    instr_d = imem_rdata;
                    tpc_d   = pc_q;
                    npc_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    req_d   = 1'b1;
                    addr_d  = pc_inc;
                    state_d = S_FETCH;
`ifdef FETCH_HALT_DETECT_EN
                    if (imem_rdata == HALT) begin
                        req_d   = 1'b0;
                        state_d = S_HALTED;
                    end
`endif
                end else begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    if (ack || !req_q) begin
                        kill_d  = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
        endcase
    end

    always_comb begin
        imem_req  = req_q;
        imem_addr = addr_q;
        halted    = (state_q == S_HALTED);
    end

    assign instr_out   = instr_q;
    assign true_pc_out = tpc_q;
    assign next_pc_out = npc_q;
    assign valid_out   = valid_q;

endmodule
